timer_cmp_ctrl: RTL and testbench
=================================

Name: timer_cmp_ctrl

Overview:
Counting and compare-match controller for the timer block. It owns the free-running 64-bit counter and its prescaler, and compares the counter against the 64-bit value held in the TCMP0 (low) and TCMP1 (high) registers. A small arming FSM suppresses spurious matches while software rewrites the compare value as two 32-bit halves. It produces the sticky interrupt status and the interrupt line read back through the register file.

Parameters:
CNT_W, 64, counter and compare width; must be 2x the register data width.
DIV_W, 4, width of the prescaler select field.
DIV_MAX, 8, largest legal div_val. Larger values freeze counting.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
timer_en  input  1  counter enable, from the control register
div_en  input  1  prescaler enable
div_val  input  DIV_W  prescale select; tick every div_val+1 cycles
int_en  input  1  interrupt output enable
cmp_val  input  CNT_W  {TCMP1, TCMP0} register contents
cmp_wr_lo  input  1  write strobe, TCMP0 (wr_en & address hit)
cmp_wr_hi  input  1  write strobe, TCMP1
cnt_wr_lo  input  1  software load of counter bits [31:0]
cnt_wr_hi  input  1  software load of counter bits [63:32]
wr_data  input  CNT_W/2  write data for counter loads
int_clr  input  1  write-1-to-clear pulse for int_st
halt_req  input  1  debug halt request (see Optional Feature)
cnt_val  output  CNT_W  current counter value
int_st  output  1  sticky compare-match status
tim_int  output  1  interrupt line = int_st & int_en
cmp_armed  output  1  1 when compare FSM is ARMED
halt_ack  output  1  halt acknowledge

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: cnt_val=0, prescaler=0, int_st=0, tim_int=0, halt_ack=0, FSM=ARMED (cmp_armed=1).
- Prescaler:
  - div_en=0: tick every cycle.
  - div_en=1 and div_val<=DIV_MAX: tick when prescaler==div_val, then the prescaler returns to 0.
  - div_val>DIV_MAX: no ticks and the prescaler holds.
  - timer_en=0 or a halt clears the prescaler to 0.
- Counter:
  - Increments by 1 on a tick when timer_en=1 and not halted.
  - Wraps from all-ones to 0 with no flag.
  - cnt_wr_lo/hi replaces the addressed half with wr_data in the next cycle. A load has priority over an increment in the same cycle, and the other half holds.
  - A load also clears the prescaler.
- Compare FSM states: ARMED, LO_PEND, HI_PEND.
  - ARMED: cmp_wr_lo only -> LO_PEND. cmp_wr_hi only -> HI_PEND. Both strobes in the same cycle -> stay ARMED.
  - LO_PEND: cmp_wr_hi -> ARMED. A repeated cmp_wr_lo keeps the state.
  - HI_PEND: cmp_wr_lo -> ARMED. A repeated cmp_wr_hi keeps the state.
  - Matching is evaluated only in ARMED, and not in the cycle of a strobe.
- Match:
  - match = ARMED & (cnt_val == cmp_val), evaluated on the registered cnt_val.
  - int_st rises one cycle after cnt_val equals cmp_val.
  - The match fires while the equality holds, i.e. the counter is paused or a divided tick is pending. int_st stays set regardless.
- int_st behaviour:
  - Sticky until an int_clr pulse.
  - If int_clr and a match occur in the same cycle, set wins.
  - tim_int is combinational from int_st and int_en.
- Reset mid-operation: all state returns to the reset values immediately. After reset, cmp_val comes out of its registers as all-ones, so no match occurs until cnt_val reaches all-ones.

Optional Feature:
TIMER_HALT_EN
- Defined:
  - halt_req=1 freezes the counter and clears the prescaler starting the next cycle.
  - halt_ack rises in that same cycle and stays high while halt_req=1.
  - halt_ack falls the cycle after halt_req drops, and counting resumes that cycle.
  - Software counter loads still take effect while halted.
- Undefined: halt_req is ignored and halt_ack is tied to 0.

Test Plan:
- Reset -> cnt_val=0, int_st=0, cmp_armed=1. Then timer_en=1, div_en=0 -> cnt_val=1,2,3 on successive cycles.
- div_en=1, div_val=3 -> cnt_val increments once per 4 cycles. div_val=9 -> cnt_val frozen.
- cmp_val=0x0000_0000_0000_0010, counting every cycle -> int_st=1 the cycle after cnt_val=0x10. tim_int=1 only when int_en=1. An int_clr pulse clears int_st; int_clr coincident with a match leaves int_st=1.
- Counter at 0x0000_0000_0000_0005. Write cmp_wr_lo with low half 0x6 (cmp_val=0x0000_0000_0000_0006) -> LO_PEND, cmp_armed=0, no int_st as cnt_val passes 6. cmp_wr_hi -> ARMED.
- Load cnt_wr_lo/hi with 0xFFFF_FFFF each -> cnt_val wraps to 0 on the next tick with no flag. With cmp_val all-ones, int_st sets while cnt_val=all-ones.
- TIMER_HALT_EN: halt_req=1 at cnt_val=0x20 -> counter holds 0x20 and halt_ack=1 from the next cycle. Release halt_req -> halt_ack=0 and counting resumes the next cycle.

Source files
------------

// File: rtl/timer_cmp_ctrl.sv
// Timer counter, prescaler and compare-match unit with sticky interrupt status.
// Optional debug halt support is built when TIMER_HALT_EN is defined.
module timer_cmp_ctrl #(
  parameter int CNT_W   = 64,
  parameter int DIV_W   = 4,
  parameter int DIV_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               timer_en,
  input  logic               div_en,
  input  logic [DIV_W-1:0]   div_val,
  input  logic               int_en,
  input  logic [CNT_W-1:0]   cmp_val,
  input  logic               cmp_wr_lo,
  input  logic               cmp_wr_hi,
  input  logic               cnt_wr_lo,
  input  logic               cnt_wr_hi,
  input  logic [CNT_W/2-1:0] wr_data,
  input  logic               int_clr,
  input  logic               halt_req,
  output logic [CNT_W-1:0]   cnt_val,
  output logic               int_st,
  output logic               tim_int,
  output logic               cmp_armed,
  output logic               halt_ack
);

  localparam int HW = CNT_W / 2;
  localparam logic [DIV_W-1:0] DIV_MAX_V = DIV_W'(DIV_MAX);

  localparam logic [1:0] ARMED   = 2'd0;
  localparam logic [1:0] LO_PEND = 2'd1;
  localparam logic [1:0] HI_PEND = 2'd2;

  logic             halted;
  logic [DIV_W-1:0] presc;
  logic             div_ok;
  logic             tick;
  logic             load;
  logic             inc;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             match;

`ifdef TIMER_HALT_EN
  logic halt_ack_q;

  assign halted = halt_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halt_ack_q <= 1'b0;
    else        halt_ack_q <= halt_req;
  end

  assign halt_ack = halt_ack_q;
`else
  logic unused_halt;

  assign unused_halt = halt_req;
  assign halted      = 1'b0;
  assign halt_ack    = 1'b0;
`endif

  // Out-of-range divider selects stop ticking entirely rather than wrapping.
  assign div_ok = (div_val <= DIV_MAX_V);
  assign tick   = !div_en || (div_ok && (presc == div_val));
  assign load   = cnt_wr_lo || cnt_wr_hi;
  assign inc    = timer_en && !halted && tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (!timer_en || halted || load || !div_en) begin
      presc <= '0;
    end else if (div_ok) begin
      presc <= tick ? '0 : presc + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_val <= '0;
    end else if (load) begin
      if (cnt_wr_lo) cnt_val[HW-1:0]     <= wr_data;
      if (cnt_wr_hi) cnt_val[CNT_W-1:HW] <= wr_data;
    end else if (inc) begin
      cnt_val <= cnt_val + CNT_W'(1);
    end
  end

  // A half-written compare value disarms matching until the other half lands.
  always_comb begin
    state_nxt = state;
    case (state)
      ARMED: begin
        if (cmp_wr_lo && !cmp_wr_hi)      state_nxt = LO_PEND;
        else if (cmp_wr_hi && !cmp_wr_lo) state_nxt = HI_PEND;
      end
      LO_PEND: if (cmp_wr_hi) state_nxt = ARMED;
      HI_PEND: if (cmp_wr_lo) state_nxt = ARMED;
      default: state_nxt = ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARMED;
    else        state <= state_nxt;
  end

  assign cmp_armed = (state == ARMED);
  assign match     = cmp_armed && !cmp_wr_lo && !cmp_wr_hi && (cnt_val == cmp_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) int_st <= 1'b0;
    else        int_st <= match || (int_st && !int_clr);
  end

  assign tim_int = int_st && int_en;

endmodule

// File: tb/tb_timer_cmp_ctrl.sv
// Directed table-driven bench for timer_cmp_ctrl, plus divider-gap and async-reset sequences.
module tb_timer_cmp_ctrl;

`ifdef TIMER_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  localparam logic [63:0] ONES = '1;
  localparam logic [63:0] K10  = 64'h10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        timer_en, div_en, int_en;
  logic [3:0]  div_val;
  logic [63:0] cmp_val;
  logic        cmp_wr_lo, cmp_wr_hi, cnt_wr_lo, cnt_wr_hi;
  logic [31:0] wr_data;
  logic        int_clr, halt_req;
  logic [63:0] cnt_val;
  logic        int_st, tim_int, cmp_armed, halt_ack;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        te, de, ie;
    logic [3:0]  dv;
    logic [63:0] cmp;
    logic        cwl, cwh, nwl, nwh;
    logic [31:0] wd;
    logic        clr, halt;
    logic [63:0] e_cnt;
    logic        e_st, e_int, e_arm, e_ack;
  } vec_t;

  vec_t vecs[$];

  timer_cmp_ctrl dut (
    .clk(clk), .rst_n(rst_n), .timer_en(timer_en), .div_en(div_en),
    .div_val(div_val), .int_en(int_en), .cmp_val(cmp_val),
    .cmp_wr_lo(cmp_wr_lo), .cmp_wr_hi(cmp_wr_hi), .cnt_wr_lo(cnt_wr_lo),
    .cnt_wr_hi(cnt_wr_hi), .wr_data(wr_data), .int_clr(int_clr),
    .halt_req(halt_req), .cnt_val(cnt_val), .int_st(int_st),
    .tim_int(tim_int), .cmp_armed(cmp_armed), .halt_ack(halt_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
  endtask

  task automatic add(input logic te, de, input logic [3:0] dv, input logic ie,
                     input logic [63:0] cmp, input logic cwl, cwh, nwl, nwh,
                     input logic [31:0] wd, input logic clr, halt,
                     input logic [63:0] e_cnt, input logic e_st, e_arm, e_ack);
    vec_t v;
    v.te = te; v.de = de; v.dv = dv; v.ie = ie; v.cmp = cmp;
    v.cwl = cwl; v.cwh = cwh; v.nwl = nwl; v.nwh = nwh; v.wd = wd;
    v.clr = clr; v.halt = halt;
    v.e_cnt = e_cnt; v.e_st = e_st; v.e_int = e_st & ie; v.e_arm = e_arm; v.e_ack = e_ack;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    timer_en = 0; div_en = 0; div_val = 0; int_en = 0; cmp_val = ONES;
    cmp_wr_lo = 0; cmp_wr_hi = 0; cnt_wr_lo = 0; cnt_wr_hi = 0;
    wr_data = 0; int_clr = 0; halt_req = 0;
  endtask

  task automatic check_all(input string tag, input int row, input logic [63:0] e_cnt,
                           input logic e_st, e_int, e_arm, e_ack);
    chk({tag, " cnt_val"},   row, cnt_val,   e_cnt);
    chk({tag, " int_st"},    row, 64'(int_st),    64'(e_st));
    chk({tag, " tim_int"},   row, 64'(tim_int),   64'(e_int));
    chk({tag, " cmp_armed"}, row, 64'(cmp_armed), 64'(e_arm));
    chk({tag, " halt_ack"},  row, 64'(halt_ack),  64'(e_ack));
  endtask

  initial begin
    logic [63:0] prev;
    int          gap;
    bit          seen;

    // te de dv ie cmp    cwl cwh nwl nwh wd          clr halt | cnt  st arm ack
    add(1,0,0,0, K10,   0,0,0,0, 32'h0,         0,0, 64'h1, 0,1,0);
    add(1,0,0,0, K10,   0,0,0,0, 32'h0,         0,0, 64'h2, 0,1,0);
    add(1,0,0,0, K10,   0,0,0,0, 32'h0,         0,0, 64'h3, 0,1,0);
    add(1,1,3,0, K10,   0,0,0,0, 32'h0,         0,0, 64'h3, 0,1,0);
    add(1,1,3,0, K10,   0,0,0,0, 32'h0,         0,0, 64'h3, 0,1,0);
    add(1,1,3,0, K10,   0,0,0,0, 32'h0,         0,0, 64'h3, 0,1,0);
    add(1,1,3,0, K10,   0,0,0,0, 32'h0,         0,0, 64'h4, 0,1,0);
    add(1,1,3,0, K10,   0,0,0,0, 32'h0,         0,0, 64'h4, 0,1,0);
    add(1,1,3,0, K10,   0,0,0,0, 32'h0,         0,0, 64'h4, 0,1,0);
    add(1,1,3,0, K10,   0,0,0,0, 32'h0,         0,0, 64'h4, 0,1,0);
    add(1,1,3,0, K10,   0,0,0,0, 32'h0,         0,0, 64'h5, 0,1,0);
    add(1,1,9,0, K10,   0,0,0,0, 32'h0,         0,0, 64'h5, 0,1,0);
    add(1,1,9,0, K10,   0,0,0,0, 32'h0,         0,0, 64'h5, 0,1,0);
    // load has priority over increment; untouched half holds
    add(1,0,0,0, K10,   0,0,0,1, 32'h0,         0,0, 64'h5, 0,1,0);
    add(1,0,0,0, K10,   0,0,1,0, 32'hE,         0,0, 64'hE, 0,1,0);
    add(1,0,0,0, K10,   0,0,0,0, 32'h0,         0,0, 64'hF, 0,1,0);
    add(1,0,0,0, K10,   0,0,0,0, 32'h0,         0,0, 64'h10,0,1,0);
    add(1,0,0,0, K10,   0,0,0,0, 32'h0,         0,0, 64'h11,1,1,0);
    add(1,0,0,1, K10,   0,0,0,0, 32'h0,         0,0, 64'h12,1,1,0);
    add(1,0,0,1, K10,   0,0,0,0, 32'h0,         1,0, 64'h13,0,1,0);
    add(0,0,0,1, K10,   0,0,1,0, 32'h10,        0,0, 64'h10,0,1,0);
    add(0,0,0,1, K10,   0,0,0,0, 32'h0,         0,0, 64'h10,1,1,0);
    add(0,0,0,1, K10,   0,0,0,0, 32'h0,         1,0, 64'h10,1,1,0);
    add(0,0,0,1, ONES,  0,0,0,0, 32'h0,         1,0, 64'h10,0,1,0);
    add(0,0,0,1, ONES,  0,0,1,0, 32'h5,         0,0, 64'h5, 0,1,0);
    // split compare write: no match while LO_PEND
    add(0,0,0,1, 64'h6, 1,0,0,0, 32'h0,         0,0, 64'h5, 0,0,0);
    add(0,0,0,1, 64'h6, 1,0,0,0, 32'h0,         0,0, 64'h5, 0,0,0);
    add(1,0,0,1, 64'h6, 0,0,0,0, 32'h0,         0,0, 64'h6, 0,0,0);
    add(1,0,0,1, 64'h6, 0,0,0,0, 32'h0,         0,0, 64'h7, 0,0,0);
    add(1,0,0,1, 64'h6, 0,0,0,0, 32'h0,         0,0, 64'h8, 0,0,0);
    add(0,0,0,1, 64'h6, 0,1,0,0, 32'h0,         0,0, 64'h8, 0,1,0);
    add(0,0,0,1, 64'h8, 1,1,0,0, 32'h0,         0,0, 64'h8, 0,1,0);
    add(0,0,0,1, 64'h8, 0,0,0,0, 32'h0,         0,0, 64'h8, 1,1,0);
    add(0,0,0,1, 64'h8, 0,1,0,0, 32'h0,         0,0, 64'h8, 1,0,0);
    add(0,0,0,1, 64'h8, 0,1,0,0, 32'h0,         0,0, 64'h8, 1,0,0);
    add(0,0,0,1, ONES,  1,0,0,0, 32'h0,         1,0, 64'h8, 0,1,0);
    // wrap through all-ones
    add(0,0,0,1, ONES,  0,0,1,1, 32'hFFFF_FFFF, 0,0, ONES,  0,1,0);
    add(0,0,0,1, ONES,  0,0,0,0, 32'h0,         0,0, ONES,  1,1,0);
    add(1,0,0,1, ONES,  0,0,0,0, 32'h0,         0,0, 64'h0, 1,1,0);
    add(1,0,0,1, ONES,  0,0,0,0, 32'h0,         1,0, 64'h1, 0,1,0);
    add(0,0,0,1, ONES,  0,0,0,1, 32'h0,         0,0, 64'h1, 0,1,0);
    add(0,0,0,1, ONES,  0,0,1,0, 32'h1F,        0,0, 64'h1F,0,1,0);
    add(1,0,0,1, ONES,  0,0,0,0, 32'h0,         0,0, 64'h20,0,1,0);
    add(1,0,0,1, ONES,  0,0,0,0, 32'h0,         0,1, HALT ? 64'h20 : 64'h21, 0,1,HALT);
    add(1,0,0,1, ONES,  0,0,1,0, 32'h40,        0,1, 64'h40,0,1,HALT);
    add(1,0,0,1, ONES,  0,0,0,0, 32'h0,         0,1, HALT ? 64'h40 : 64'h41, 0,1,HALT);
    add(1,0,0,1, ONES,  0,0,0,0, 32'h0,         0,0, HALT ? 64'h41 : 64'h42, 0,1,0);

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 64'h0, 0, 0, 1, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      timer_en = vecs[i].te; div_en = vecs[i].de; div_val = vecs[i].dv;
      int_en = vecs[i].ie; cmp_val = vecs[i].cmp;
      cmp_wr_lo = vecs[i].cwl; cmp_wr_hi = vecs[i].cwh;
      cnt_wr_lo = vecs[i].nwl; cnt_wr_hi = vecs[i].nwh; wr_data = vecs[i].wd;
      int_clr = vecs[i].clr; halt_req = vecs[i].halt;
      @(posedge clk);
      #1;
      check_all("vec", i + 1, vecs[i].e_cnt, vecs[i].e_st, vecs[i].e_int,
                vecs[i].e_arm, vecs[i].e_ack);
    end

    // div_val = DIV_MAX: one increment every 9 cycles
    idle_inputs();
    timer_en = 1; div_en = 1; div_val = 4'd8;
    seen = 0;
    prev = cnt_val;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (cnt_val !== prev) seen = 1;
    end
    prev = cnt_val;
    gap = 0;
    if (seen) begin
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(posedge clk); #1;
        gap++;
        if (cnt_val !== prev) seen = 1;
      end
    end
    chk("div8 gap", -1, 64'(seen ? gap : -1), 64'd9);

    // asynchronous reset in the middle of a pending compare write
    idle_inputs();
    int_en = 1; cmp_val = 64'h77;
    cnt_wr_hi = 1; wr_data = 32'h0;
    @(posedge clk); #1;
    cnt_wr_hi = 0; cnt_wr_lo = 1; wr_data = 32'h77;
    @(posedge clk); #1;
    cnt_wr_lo = 0;
    @(posedge clk); #1;
    chk("pre-reset int_st", -2, 64'(int_st), 64'd1);
    cmp_wr_lo = 1;
    @(posedge clk); #1;
    cmp_wr_lo = 0;
    chk("pre-reset cmp_armed", -2, 64'(cmp_armed), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async reset", -2, 64'h0, 0, 0, 1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
